// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: per-channel synchroniser, stability filter,
// registered edge pulses and a one-shot long-press pulse.
module button_debouncer #(
  parameter int CHANNELS_G      = 4,
  parameter int SYNC_STAGES_G   = 2,
  parameter int STABLE_CYCLES_G = 1_000_000,
  parameter int HOLD_CYCLES_G   = 50_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [CHANNELS_G-1:0] signal_i,
  output logic [CHANNELS_G-1:0] level_o,
  output logic [CHANNELS_G-1:0] pedge_o,
  output logic [CHANNELS_G-1:0] nedge_o,
  output logic [CHANNELS_G-1:0] hold_o
);

  localparam int STAB_W = $clog2(STABLE_CYCLES_G + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES_G + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES_G - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES_G);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES_G - 1);

  for (genvar gi = 0; gi < CHANNELS_G; gi++) begin : g_ch
    logic [SYNC_STAGES_G-1:0] sync_reg;
    logic                     s;
    logic [STAB_W-1:0]        stab_reg, stab_next;
    logic [HOLD_W-1:0]        hold_cnt_reg, hold_cnt_next;
    logic                     level_reg, level_next;
    logic                     pedge_reg, pedge_next;
    logic                     nedge_reg, nedge_next;
    logic                     hold_reg, hold_next;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES_G-2:0], signal_i[gi]};
      end
    end

    assign s = sync_reg[SYNC_STAGES_G-1];

    // A mismatch must survive STABLE_CYCLES_G consecutive edges; any agreement restarts the count.
    always_comb begin
      stab_next  = '0;
      level_next = level_reg;
      pedge_next = 1'b0;
      nedge_next = 1'b0;
      if (s != level_reg) begin
        if (stab_reg == STAB_LAST) begin
          level_next = s;
          pedge_next = s;
          nedge_next = !s;
        end else begin
          stab_next = stab_reg + 1'b1;
        end
      end
    end

    // Counting only while the level is and stays high lets a same-edge release veto the pulse.
    always_comb begin
      hold_cnt_next = '0;
      hold_next     = 1'b0;
      if (level_reg && level_next) begin
        hold_cnt_next = hold_cnt_reg;
        if (hold_cnt_reg != HOLD_MAX) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
          hold_next     = (hold_cnt_reg == HOLD_LAST);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        stab_reg     <= '0;
        hold_cnt_reg <= '0;
        level_reg    <= 1'b0;
        pedge_reg    <= 1'b0;
        nedge_reg    <= 1'b0;
        hold_reg     <= 1'b0;
      end else begin
        stab_reg     <= stab_next;
        hold_cnt_reg <= hold_cnt_next;
        level_reg    <= level_next;
        pedge_reg    <= pedge_next;
        nedge_reg    <= nedge_next;
        hold_reg     <= hold_next;
      end
    end

    assign level_o[gi] = level_reg;
    assign pedge_o[gi] = pedge_reg;
    assign nedge_o[gi] = nedge_reg;
    assign hold_o[gi]  = hold_reg;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two parameterisations driven by shared stimulus and
// checked every cycle against a window-based behavioural model, plus literal timing checks.
module tb_button_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] signal;
  logic [1:0] level_a, pedge_a, nedge_a, hold_a;
  logic [1:0] level_b, pedge_b, nedge_b, hold_b;

  button_debouncer #(
    .CHANNELS_G(2), .SYNC_STAGES_G(2), .STABLE_CYCLES_G(4), .HOLD_CYCLES_G(10)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .signal_i(signal),
    .level_o(level_a), .pedge_o(pedge_a), .nedge_o(nedge_a), .hold_o(hold_a)
  );

  button_debouncer #(
    .CHANNELS_G(2), .SYNC_STAGES_G(3), .STABLE_CYCLES_G(1), .HOLD_CYCLES_G(10)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .signal_i(signal),
    .level_o(level_b), .pedge_o(pedge_b), .nedge_o(nedge_b), .hold_o(hold_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: hist[i][0] is the raw input sampled at the current edge; the synchronised value
  // used at that edge is the raw sample from SYNC edges earlier. The level flips when the
  // last STABLE synchronised samples all disagree with it. hold fires HOLD edges after a rise.
  logic [1:0] hist [2][16];
  logic [1:0] mlev [2];
  logic [1:0] mped [2];
  logic [1:0] mned [2];
  logic [1:0] mhold[2];
  int         age  [2][2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) hist[i][k] = 2'b00;
      mlev[i] = 2'b00; mped[i] = 2'b00; mned[i] = 2'b00; mhold[i] = 2'b00;
      age[i][0] = 0; age[i][1] = 0;
    end
  endtask

  task automatic model_step(input int i, input int sync_n, input int stab_n, input int hold_n);
    logic [1:0] prev;
    bit all_diff;
    prev = mlev[i];
    for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = signal;
    for (int ch = 0; ch < 2; ch++) begin
      all_diff = 1'b1;
      for (int k = sync_n; k < sync_n + stab_n; k++)
        if (hist[i][k][ch] == prev[ch]) all_diff = 1'b0;
      if (all_diff) mlev[i][ch] = ~prev[ch];
      mped[i][ch]  = mlev[i][ch] & ~prev[ch];
      mned[i][ch]  = ~mlev[i][ch] & prev[ch];
      mhold[i][ch] = 1'b0;
      if (mped[i][ch]) begin
        age[i][ch] = 0;
      end else if (mlev[i][ch] && prev[ch]) begin
        age[i][ch]   = age[i][ch] + 1;
        mhold[i][ch] = (age[i][ch] == hold_n);
      end else begin
        age[i][ch] = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, 2, 4, 10);
      model_step(1, 3, 1, 10);
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pc[2][2], nc[2][2], hc[2][2];
  int pcyc[2][2], ncyc[2][2], hcyc[2][2];

  function automatic logic [7:0] dut_out(input int i);
    return (i == 0) ? {hold_a, nedge_a, pedge_a, level_a} : {hold_b, nedge_b, pedge_b, level_b};
  endfunction

  function automatic logic [7:0] model_out(input int i);
    return {mhold[i], mned[i], mped[i], mlev[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] d;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      d = dut_out(i);
      for (int ch = 0; ch < 2; ch++) begin
        if (d[2+ch] === 1'b1) begin pc[i][ch]++; pcyc[i][ch] = cyc; end
        if (d[4+ch] === 1'b1) begin nc[i][ch]++; ncyc[i][ch] = cyc; end
        if (d[6+ch] === 1'b1) begin hc[i][ch]++; hcyc[i][ch] = cyc; end
      end
      chk($sformatf("model_inst%0d_cyc%0d", i, cyc), {24'd0, d}, {24'd0, model_out(i)});
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int c0, rel, p0, n0, h0, n1, pb0, nb0, hb0;
    int rem[2];
    for (int i = 0; i < 2; i++)
      for (int ch = 0; ch < 2; ch++) begin
        pc[i][ch] = 0; nc[i][ch] = 0; hc[i][ch] = 0;
        pcyc[i][ch] = -1; ncyc[i][ch] = -1; hcyc[i][ch] = -1;
      end
    rst_n  = 1'b0;
    signal = 2'b00;
    ticks(3);
    chk("reset_outputs_a", {24'd0, dut_out(0)}, 32'd0);
    chk("reset_outputs_b", {24'd0, dut_out(1)}, 32'd0);
    rst_n = 1'b1;
    ticks(10);

    // Clean press on channel 0
    c0 = cyc; signal = 2'b01;
    ticks(20);
    chk("clean_latency_a", pcyc[0][0] - c0, 6);
    chk("clean_latency_b", pcyc[1][0] - c0, 4);
    chk("clean_hold_a", hcyc[0][0] - pcyc[0][0], 10);
    chk("clean_hold_b", hcyc[1][0] - pcyc[1][0], 10);
    chk("clean_ch1_quiet", pc[0][1] + nc[0][1] + hc[0][1] + pc[1][1] + nc[1][1] + hc[1][1], 0);
    signal = 2'b00;
    ticks(20);

    // Bounce: 3 high, 1 low, then 10 high
    p0 = pc[0][0]; n0 = nc[0][0];
    c0 = cyc; signal = 2'b01;
    ticks(3);
    signal = 2'b00; ticks(1);
    signal = 2'b01; ticks(10);
    chk("bounce_single_pedge", pc[0][0] - p0, 1);
    chk("bounce_no_nedge", nc[0][0] - n0, 0);
    chk("bounce_pedge_time", pcyc[0][0] - c0, 10);
    signal = 2'b00;
    ticks(20);

    // Short press of 8 cycles
    p0 = pc[0][0]; n0 = nc[0][0]; h0 = hc[0][0];
    signal = 2'b01; ticks(8);
    signal = 2'b00; ticks(20);
    chk("short_pedge", pc[0][0] - p0, 1);
    chk("short_nedge", nc[0][0] - n0, 1);
    chk("short_no_hold", hc[0][0] - h0, 0);

    // Release lands exactly on the hold count
    h0 = hc[0][0]; hb0 = hc[1][0];
    signal = 2'b01; ticks(10);
    signal = 2'b00; ticks(20);
    chk("exact_release_gap_a", ncyc[0][0] - pcyc[0][0], 10);
    chk("exact_release_no_hold_a", hc[0][0] - h0, 0);
    chk("exact_release_gap_b", ncyc[1][0] - pcyc[1][0], 10);
    chk("exact_release_no_hold_b", hc[1][0] - hb0, 0);

    // One cycle longer: hold fires once
    h0 = hc[0][0];
    signal = 2'b01; ticks(11);
    signal = 2'b00; ticks(20);
    chk("late_release_hold_a", hc[0][0] - h0, 1);

    // Simultaneous press ch0 / release ch1
    signal = 2'b10; ticks(25);
    c0 = cyc; signal = 2'b01;
    ticks(15);
    chk("simul_pedge0_time", pcyc[0][0] - c0, 6);
    chk("simul_same_cycle_a", pcyc[0][0] - ncyc[0][1], 0);
    chk("simul_same_cycle_b", pcyc[1][0] - ncyc[1][1], 0);

    // Reset while the channel 0 stability count is 2
    signal = 2'b10; ticks(25);
    n0 = nc[0][0]; n1 = nc[0][1]; nb0 = nc[1][0];
    signal = 2'b11; ticks(4);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs_a", {24'd0, dut_out(0)}, 32'd0);
    chk("midreset_outputs_b", {24'd0, dut_out(1)}, 32'd0);
    ticks(3);
    rst_n = 1'b1; rel = cyc;
    ticks(12);
    chk("post_reset_pedge0_a", pcyc[0][0] - rel, 6);
    chk("post_reset_pedge1_a", pcyc[0][1] - rel, 6);
    chk("post_reset_pedge0_b", pcyc[1][0] - rel, 4);
    chk("post_reset_no_nedge", (nc[0][0] - n0) + (nc[0][1] - n1) + (nc[1][0] - nb0), 0);
    signal = 2'b00; ticks(20);

    // Randomised run lengths per channel with occasional resets
    pb0 = pc[0][0] + pc[0][1]; h0 = hc[0][0] + hc[0][1];
    rem[0] = 0; rem[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          signal[ch] = ~signal[ch];
          rem[ch] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 25));
        end
        rem[ch]--;
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
      end
      tick();
    end
    chk("random_saw_presses", ((pc[0][0] + pc[0][1] - pb0) > 20) ? 32'd1 : 32'd0, 32'd1);
    chk("random_saw_holds", ((hc[0][0] + hc[0][1] - h0) > 5) ? 32'd1 : 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
